// File: rtl/signed_divider.sv
// Sequential signed divider: restoring division over magnitudes, start/done.
// Optional divide-by-zero flag output (dbz) enabled by DIV_ZERO_FLAG_EN.
module signed_divider #(
    parameter int M = 3,
    parameter int N = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [M+N-1:0] P,
    input  logic [N-1:0]   B,
    output logic [M+N-1:0] Q,
    output logic [N-1:0]   R,
    output logic           busy,
    output logic           done,
    output logic           ovf
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic           dbz
`endif
);

    localparam int W  = M + N;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_t;

    state_t state, state_nx;

    // |P| and |B| carry one extra bit so the most negative inputs are exact
    logic [W:0]    pmag, pmag_nx;
    logic [N:0]    bmag, bmag_nx;
    logic [N:0]    rem, rem_nx;
    logic [W-1:0]  qmag, qmag_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          sign_q, sign_q_nx;
    logic          sign_r, sign_r_nx;
    logic          bzero, bzero_nx;

    logic [W-1:0]  q_nx;
    logic [N-1:0]  r_nx;
    logic          busy_nx;
    logic          done_nx;
    logic          ovf_nx;

    logic [W:0]    pext, pabs;
    logic [N:0]    bext, babs;
    logic [N+1:0]  shifted, trial;
    logic          qbit;

    // sign-extend operands and take magnitudes in the widened form
    always_comb begin
        pext = {P[W-1], P};
        bext = {B[N-1], B};
        pabs = pext[W] ? -pext : pext;
        babs = bext[N] ? -bext : bext;
    end

    // one restoring step: bring in next dividend bit, trial-subtract |B|
    always_comb begin
        shifted = {rem, pmag[W-1]};
        trial   = shifted - {1'b0, bmag};
        qbit    = bzero | ~trial[N+1];
    end

    // next-state and datapath updates for IDLE/DIV/FIX
    always_comb begin
        state_nx  = state;
        pmag_nx   = pmag;
        bmag_nx   = bmag;
        rem_nx    = rem;
        qmag_nx   = qmag;
        cnt_nx    = cnt;
        sign_q_nx = sign_q;
        sign_r_nx = sign_r;
        bzero_nx  = bzero;
        q_nx      = Q;
        r_nx      = R;
        busy_nx   = busy;
        done_nx   = 1'b0;
        ovf_nx    = ovf;

        unique case (state)
            IDLE: begin
                // the done cycle sits in IDLE but must not accept a new job
                if (start && !done) begin
                    pmag_nx   = pabs;
                    bmag_nx   = babs;
                    rem_nx    = '0;
                    qmag_nx   = '0;
                    cnt_nx    = CW'(W - 1);
                    sign_q_nx = P[W-1] ^ B[N-1];
                    sign_r_nx = P[W-1];
                    bzero_nx  = (B == '0);
                    busy_nx   = 1'b1;
                    state_nx  = DIV;
                end
            end

            DIV: begin
                pmag_nx = pmag << 1;
                qmag_nx = {qmag[W-2:0], qbit};
                if (bzero) begin
                    rem_nx = '0;
                end else if (!trial[N+1]) begin
                    rem_nx = trial[N:0];
                end else begin
                    rem_nx = shifted[N:0];
                end
                cnt_nx = cnt - CW'(1);
                if (cnt == '0) begin
                    state_nx = FIX;
                end
            end

            FIX: begin
                q_nx = sign_q ? -qmag : qmag;
                if (bzero) begin
                    r_nx = '0;
                end else begin
                    r_nx = sign_r ? -rem[N-1:0] : rem[N-1:0];
                end
                // a positive quotient with the top bit set only arises
                // from the most negative dividend over -1
                ovf_nx   = ~bzero & ~sign_q & qmag[W-1];
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                state_nx = IDLE;
            end

            default: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            pmag   <= '0;
            bmag   <= '0;
            rem    <= '0;
            qmag   <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            bzero  <= 1'b0;
            Q      <= '0;
            R      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nx;
            pmag   <= pmag_nx;
            bmag   <= bmag_nx;
            rem    <= rem_nx;
            qmag   <= qmag_nx;
            cnt    <= cnt_nx;
            sign_q <= sign_q_nx;
            sign_r <= sign_r_nx;
            bzero  <= bzero_nx;
            Q      <= q_nx;
            R      <= r_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            ovf    <= ovf_nx;
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    // divide-by-zero flag, published together with the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbz <= 1'b0;
        end else if (state == FIX) begin
            dbz <= bzero;
        end
    end
`endif

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider (defaults M=3, N=2).
// Driver pushes expected results; a negedge monitor pops on done.
module tb_signed_divider;

    localparam int W = 5;
    localparam int N = 2;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic signed [W-1:0] P     = '0;
    logic signed [N-1:0] B     = '0;
    logic signed [W-1:0] Q;
    logic signed [N-1:0] R;
    logic                busy;
    logic                done;
    logic                ovf;
`ifdef DIV_ZERO_FLAG_EN
    logic                dbz;
`endif

    signed_divider #(.M(3), .N(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .P     (P),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .dbz   (dbz)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] p;
        logic signed [N-1:0] b;
        logic signed [W-1:0] q;
        logic signed [N-1:0] r;
        logic                o;
        logic                z;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void chk(string nm, int got, int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endfunction

    // monitor: compare each done pulse against the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        int   ar, ab;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 expected none pending");
            end else begin
                e = sb.pop_front();
                chk($sformatf("Q p=%0d b=%0d", e.p, e.b), Q, e.q);
                chk($sformatf("R p=%0d b=%0d", e.p, e.b), R, e.r);
                chk($sformatf("ovf p=%0d b=%0d", e.p, e.b), ovf, e.o);
`ifdef DIV_ZERO_FLAG_EN
                chk($sformatf("dbz p=%0d b=%0d", e.p, e.b), dbz, e.z);
`endif
                if (e.b != 0 && !e.o) begin
                    ar = (R < 0) ? -int'(R) : int'(R);
                    ab = (e.b < 0) ? -int'(e.b) : int'(e.b);
                    chk($sformatf("identity p=%0d b=%0d", e.p, e.b),
                        int'(Q) * int'(e.b) + int'(R), int'(e.p));
                    chk($sformatf("rem_mag p=%0d b=%0d", e.p, e.b),
                        (ar < ab) ? 1 : 0, 1);
                    chk($sformatf("rem_sign p=%0d b=%0d", e.p, e.b),
                        (R == 0 || ((R < 0) == (e.p < 0))) ? 1 : 0, 1);
                end
            end
        end
    end

    function automatic void model(input int p, input int b,
                                  output int q, output int r,
                                  output bit o);
        o = 1'b0;
        if (b == 0) begin
            q = (p >= 0) ? -1 : 1;
            r = 0;
        end else if (p == -16 && b == -1) begin
            q = -16;
            r = 0;
            o = 1'b1;
        end else begin
            q = p / b;
            r = p % b;
        end
    endfunction

    task automatic issue(input int p, input int b, input int q,
                         input int r, input bit o);
        exp_t e;
        e.p = W'(p);
        e.b = N'(b);
        e.q = W'(q);
        e.r = N'(r);
        e.o = o;
        e.z = (b == 0);
        sb.push_back(e);
        P     = W'(p);
        B     = N'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run(input int p, input int b, input int q,
                       input int r, input bit o);
        int lat, bc;
        issue(p, b, q, r, o);
        wait_done(lat, bc);
        chk($sformatf("latency p=%0d b=%0d", p, b), lat, W + 1);
        chk($sformatf("busy_cycles p=%0d b=%0d", p, b), bc, W + 1);
        chk($sformatf("busy_in_done p=%0d b=%0d", p, b), busy, 0);
        @(negedge clk);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_Q"}, Q, 0);
        chk({tag, "_R"}, R, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ovf"}, ovf, 0);
`ifdef DIV_ZERO_FLAG_EN
        chk({tag, "_dbz"}, dbz, 0);
`endif
    endtask

    initial begin : drv
        int lat, bc, seen, q, r;
        bit o;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(7, -2, -3, 1, 1'b0);
        run(-7, -2, 3, -1, 1'b0);
        run(-7, 1, -7, 0, 1'b0);
        run(-16, -1, -16, 0, 1'b1);
        run(-16, 1, -16, 0, 1'b0);
        run(5, 0, -1, 0, 1'b0);
        run(-5, 0, 1, 0, 1'b0);

        // start while busy and start in the done cycle are both dropped
        issue(7, -2, -3, 1, 1'b0);
        @(negedge clk);
        P     = 5'sd3;
        B     = 2'sd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        chk("ignored_latency", lat, W - 1);
        P     = 5'sd3;
        B     = 2'sd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        repeat (8) begin
            if (busy) seen = 1;
            @(negedge clk);
        end
        chk("start_in_done_ignored", seen, 0);
        chk("Q_hold", Q, -3);
        chk("R_hold", R, 1);

        // reset mid-division discards the job
        issue(7, -2, -3, 1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        sb.delete();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_done_after_reset", done, 0);
        run(-16, -2, 8, 0, 1'b0);

        // every (P, B) pair
        for (int p = -16; p <= 15; p++) begin
            for (int b = -2; b <= 1; b++) begin
                model(p, b, q, r, o);
                run(p, b, q, r, o);
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
